// File: rtl/sysctrl_initiator.sv
// Initiator end of the system-control byte link: frames host requests into
// start/strobe/byte transfers, collects replies and services int_n.
module sysctrl_initiator #(
  parameter int MAX_PL      = 7,
  parameter int GAP         = 3,
  parameter int AUTO_IRQ    = 1,
  parameter int IRQ_HOLDOFF = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_cmd,
  input  logic [3:0]            req_len,
  input  logic [8*MAX_PL-1:0]   req_data,
  output logic                  rsp_valid,
  output logic [3:0]            rsp_len,
  output logic [8*MAX_PL-1:0]   rsp_data,
  output logic                  busy,
  output logic                  strobe,
  output logic                  start,
  output logic [7:0]            tx_data,
  input  logic [7:0]            rx_data,
  input  logic                  int_n,
  output logic                  irq_valid,
  output logic [7:0]            irq_status
);

  // state   | meaning
  // IDLE    | waiting for a host request or an interrupt to service
  // STROBE  | one-cycle byte strobe (command at idx 0, else payload idx-1)
  // WAIT    | GAP quiet cycles; reply to previous strobe captured on first
  // CAPTURE | capture reply to the final strobe
  // DONE    | completion pulse, or chain READ into ACK
  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_HOST, PH_READ, PH_ACK} phase_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_PL);
  localparam logic [7:0] IRQ_CMD = 8'h05;

  state_t                state;
  phase_t                phase;
  logic [3:0]            len_q;
  logic [3:0]            idx;
  logic [7:0]            wcnt;
  logic [15:0]           holdoff;
  logic [7:0]            status_q;
  logic [8*MAX_PL-1:0]   pl_q;
  logic [8*MAX_PL-1:0]   reply_q;
  logic [8*MAX_PL-1:0]   reply_cap;
  logic [3:0]            cap_idx;
  logic                  capture_en;
  logic [7:0]            next_tx;
  logic [3:0]            req_len_c;
  logic                  irq_go;

  assign req_len_c = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign irq_go    = (AUTO_IRQ != 0) && !int_n && (holdoff == '0) && !req_valid;

  always_comb begin
    cap_idx    = idx - 4'd1;
    capture_en = (idx != 4'd0) &&
                 (((state == S_WAIT) && (wcnt == 8'(GAP-1))) || (state == S_CAPTURE));
    reply_cap  = reply_q;
    if (capture_en) reply_cap[8*cap_idx +: 8] = rx_data;
    next_tx    = pl_q[8*idx +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= PH_HOST;
      len_q      <= '0;
      idx        <= '0;
      wcnt       <= '0;
      holdoff    <= '0;
      status_q   <= '0;
      pl_q       <= '0;
      reply_q    <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_len    <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      strobe     <= 1'b0;
      start      <= 1'b0;
      tx_data    <= '0;
      irq_valid  <= 1'b0;
      irq_status <= '0;
    end else begin
      rsp_valid <= 1'b0;
      irq_valid <= 1'b0;
      strobe    <= 1'b0;
      start     <= 1'b0;
      reply_q   <= reply_cap;
      if (holdoff != '0) holdoff <= holdoff - 16'd1;

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            len_q     <= req_len_c;
            pl_q      <= req_data;
            reply_q   <= '0;
            idx       <= '0;
            phase     <= PH_HOST;
            state     <= S_STROBE;
            strobe    <= 1'b1;
            start     <= 1'b1;
            tx_data   <= req_cmd;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else if (irq_go && req_ready) begin
            len_q     <= 4'd1;
            pl_q      <= '0;
            reply_q   <= '0;
            idx       <= '0;
            phase     <= PH_READ;
            state     <= S_STROBE;
            strobe    <= 1'b1;
            start     <= 1'b1;
            tx_data   <= IRQ_CMD;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_STROBE: begin
          if (idx == len_q) begin
            state <= S_CAPTURE;
          end else begin
            state <= S_WAIT;
            wcnt  <= 8'(GAP-1);
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            state   <= S_STROBE;
            strobe  <= 1'b1;
            tx_data <= next_tx;
            idx     <= idx + 4'd1;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          state <= S_DONE;
          case (phase)
            PH_HOST: begin
              rsp_valid <= 1'b1;
              rsp_data  <= reply_cap;
              rsp_len   <= len_q;
            end
            PH_READ: status_q <= reply_cap[7:0];
            default: begin
              irq_valid  <= 1'b1;
              irq_status <= status_q;
            end
          endcase
        end
        S_DONE: begin
          // A non-zero status must be acknowledged before the link is released
          if ((phase == PH_READ) && (status_q != 8'd0)) begin
            pl_q       <= '0;
            pl_q[7:0]  <= status_q;
            len_q      <= 4'd1;
            reply_q    <= '0;
            idx        <= '0;
            phase      <= PH_ACK;
            state      <= S_STROBE;
            strobe     <= 1'b1;
            start      <= 1'b1;
            tx_data    <= IRQ_CMD;
          end else begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            if (phase == PH_ACK) holdoff <= 16'(IRQ_HOLDOFF);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysctrl_initiator.sv
// Self-checking bench for sysctrl_initiator: responder model, strobe/pulse
// logger and a framing-rule reference model for random host requests.
module tb_sysctrl_initiator;
  localparam int MAX_PL = 7;
  localparam int GAP    = 3;
  localparam int W      = 8*MAX_PL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_cmd = '0;
  logic [3:0]    req_len = '0;
  logic [W-1:0]  req_data = '0;
  logic          rsp_valid;
  logic [3:0]    rsp_len;
  logic [W-1:0]  rsp_data;
  logic          busy, strobe, start;
  logic [7:0]    tx_data;
  logic [7:0]    rx_data = '0;
  logic          int_n = 1'b1;
  logic          irq_valid;
  logic [7:0]    irq_status;

  sysctrl_initiator #(.MAX_PL(MAX_PL), .GAP(GAP), .AUTO_IRQ(1), .IRQ_HOLDOFF(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_len(rsp_len), .rsp_data(rsp_data),
    .busy(busy), .strobe(strobe), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .int_n(int_n),
    .irq_valid(irq_valid), .irq_status(irq_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: reply to payload byte n with resp_bytes[n], junk to commands
  logic [7:0] resp_bytes [16];
  int rbyte = 0;
  always @(posedge clk) begin
    if (strobe) begin
      if (start) begin
        rbyte   <= 0;
        rx_data <= 8'($urandom);
      end else begin
        rx_data <= resp_bytes[rbyte % 16];
        rbyte   <= rbyte + 1;
      end
    end
  end

  int         st_cyc[$];
  logic [7:0] st_data[$];
  logic       st_start[$];
  int         rdy_cyc[$];
  int         rsp_cnt = 0, rsp_cyc = 0, irq_cnt = 0, irq_cyc = 0;

  always @(negedge clk) begin
    if (strobe) begin
      st_cyc.push_back(cyc);
      st_data.push_back(tx_data);
      st_start.push_back(start);
    end
    if (req_ready) rdy_cyc.push_back(cyc);
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; end
    if (irq_valid) begin irq_cnt++; irq_cyc = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs;
    st_cyc.delete(); st_data.delete(); st_start.delete(); rdy_cyc.delete();
    rsp_cnt = 0; irq_cnt = 0;
  endtask

  task automatic launch(input logic [7:0] c, input logic [3:0] l,
                        input logic [W-1:0] d, output int acc);
    int n = 0;
    while (!req_ready && n < 100) begin tick(1); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
    end
    req_cmd = c; req_len = l; req_data = d; req_valid = 1'b1; acc = cyc;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (rsp_cnt == 0 && n < budget) begin tick(1); n++; end
    checks++;
    if (rsp_cnt == 0) begin
      errors++; $display("FAIL rsp_timeout: rsp_valid count=0 required >=1");
    end
    tick(4);
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq_cnt == 0 && n < budget) begin tick(1); n++; end
    checks++;
    if (irq_cnt == 0) begin
      errors++; $display("FAIL irq_timeout: irq_valid count=0 required >=1");
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({strobe, start, rsp_valid, busy, irq_valid, req_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: strobe/start/rsp_valid/busy/irq_valid/req_ready=%b required 000000",
               {strobe, start, rsp_valid, busy, irq_valid, req_ready});
    end
    checks++;
    if ({tx_data, rsp_len, rsp_data, irq_status} !== '0) begin
      errors++; $display("FAIL reset_data: tx=%h len=%h rsp=%h st=%h required 0",
                         tx_data, rsp_len, rsp_data, irq_status);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic test_basic_frames;
    int c;
    // status-read style request
    resp_bytes[0] = 8'h5C; resp_bytes[1] = 8'h42; resp_bytes[2] = 8'h02;
    clear_logs();
    launch(8'h00, 4'd3, '0, c);
    wait_rsp(60);
    checks++;
    if (st_cyc.size() != 4) begin
      errors++; $display("FAIL frame1_strobe_count: got %0d required 4", st_cyc.size());
    end
    for (int k = 0; k < st_cyc.size() && k < 4; k++) begin
      checks++;
      if (st_cyc[k] != c + 1 + k*(GAP+1) || st_start[k] !== (k == 0)) begin
        errors++; $display("FAIL frame1_strobe%0d: cycle +%0d start %0b required +%0d start %0b",
                           k, st_cyc[k] - c, st_start[k], 1 + k*(GAP+1), k == 0);
      end
    end
    checks++;
    if (rsp_data !== 56'h02425C || rsp_len !== 4'd3) begin
      errors++; $display("FAIL frame1_rsp: data %h len %0d required 02425c len 3", rsp_data, rsp_len);
    end

    // payload ordering and single completion pulse
    clear_logs();
    launch(8'h02, 4'd3, 56'h804020, c);
    wait_rsp(60);
    checks++;
    if (st_data.size() != 4 || st_data[0] !== 8'h02 || st_data[1] !== 8'h20 ||
        st_data[2] !== 8'h40 || st_data[3] !== 8'h80) begin
      errors++; $display("FAIL frame2_tx_order: %0d strobes, first bytes %h %h required 02 20 40 80",
                         st_data.size(), st_data.size() > 0 ? st_data[0] : 8'hxx,
                         st_data.size() > 1 ? st_data[1] : 8'hxx);
    end
    checks++;
    if (rsp_cnt != 1 || rsp_cyc != c + 15) begin
      errors++; $display("FAIL frame2_rsp_timing: %0d pulses at +%0d required 1 at +15",
                         rsp_cnt, rsp_cyc - c);
    end
    checks++;
    if (tx_data !== 8'h80) begin
      errors++; $display("FAIL frame2_tx_hold: tx_data %h required 80", tx_data);
    end

    // command-only request
    clear_logs();
    launch(8'h07, 4'd0, 56'hFFFFFF, c);
    wait_rsp(30);
    checks++;
    if (st_cyc.size() != 1 || st_start[0] !== 1'b1 || st_data[0] !== 8'h07) begin
      errors++; $display("FAIL frame3_strobe: %0d strobes required 1 (cmd 07, start)", st_cyc.size());
    end
    checks++;
    if (rsp_cyc != c + 3 || rsp_len !== 4'd0 || rsp_data !== '0) begin
      errors++; $display("FAIL frame3_rsp: at +%0d len %0d data %h required +3 len 0 data 0",
                         rsp_cyc - c, rsp_len, rsp_data);
    end
  endtask

  task automatic test_random_requests;
    for (int t = 0; t < 20; t++) begin
      logic [7:0]   cmd;
      logic [3:0]   len;
      logic [W-1:0] data, exp_rsp;
      logic [7:0]   exp_last;
      int           clen, c;
      cmd  = 8'($urandom);
      len  = 4'($urandom_range(0, 15));
      data = W'({$urandom, $urandom});
      for (int k = 0; k < 16; k++) resp_bytes[k] = 8'($urandom);
      clen = (int'(len) > MAX_PL) ? MAX_PL : int'(len);
      exp_rsp = '0;
      for (int k = 0; k < clen; k++) exp_rsp[8*k +: 8] = resp_bytes[k];
      exp_last = (clen == 0) ? cmd : data[8*(clen-1) +: 8];
      clear_logs();
      launch(cmd, len, data, c);
      wait_rsp(80);
      checks++;
      if (st_cyc.size() != clen + 1) begin
        errors++; $display("FAIL rand%0d_strobe_count: got %0d required %0d", t, st_cyc.size(), clen + 1);
      end
      for (int k = 0; k < st_cyc.size() && k <= clen; k++) begin
        logic [7:0] eb;
        eb = (k == 0) ? cmd : data[8*(k-1) +: 8];
        checks++;
        if (st_data[k] !== eb || st_start[k] !== (k == 0) || st_cyc[k] != c + 1 + k*(GAP+1)) begin
          errors++; $display("FAIL rand%0d_strobe%0d: byte %h start %0b at +%0d required %h %0b +%0d",
                             t, k, st_data[k], st_start[k], st_cyc[k] - c, eb, k == 0, 1 + k*(GAP+1));
        end
      end
      checks++;
      if (rsp_cnt != 1 || rsp_cyc != c + 3 + clen*(GAP+1)) begin
        errors++; $display("FAIL rand%0d_rsp_timing: %0d pulses at +%0d required 1 at +%0d",
                           t, rsp_cnt, rsp_cyc - c, 3 + clen*(GAP+1));
      end
      checks++;
      if (rsp_data !== exp_rsp || rsp_len !== 4'(clen)) begin
        errors++; $display("FAIL rand%0d_rsp_data: %h len %0d required %h len %0d",
                           t, rsp_data, rsp_len, exp_rsp, clen);
      end
      checks++;
      if (tx_data !== exp_last) begin
        errors++; $display("FAIL rand%0d_tx_hold: %h required %h", t, tx_data, exp_last);
      end
    end
  endtask

  task automatic test_irq;
    int n_hold, n_late, n_rdy;
    resp_bytes[0] = 8'h01;
    clear_logs();
    int_n = 1'b0;
    wait_irq(100);
    tick(12);
    checks++;
    if (st_data.size() < 4 || st_data[0] !== 8'h05 || st_start[0] !== 1'b1 ||
        st_data[1] !== 8'h00 || st_start[1] !== 1'b0 || st_data[2] !== 8'h05 ||
        st_start[2] !== 1'b1 || st_data[3] !== 8'h01 || st_start[3] !== 1'b0) begin
      errors++; $display("FAIL irq_sequence: %0d strobes, required 05* 00 05* 01", st_data.size());
    end
    checks++;
    if (irq_cnt != 1 || irq_status !== 8'h01 || rsp_cnt != 0) begin
      errors++; $display("FAIL irq_pulse: irq %0d status %h rsp %0d required 1 01 0",
                         irq_cnt, irq_status, rsp_cnt);
    end
    n_hold = 0; n_late = 0; n_rdy = 0;
    foreach (st_cyc[k]) begin
      if (st_cyc[k] > irq_cyc && st_cyc[k] <= irq_cyc + 8) n_hold++;
      if (st_cyc[k] > irq_cyc + 8) n_late++;
    end
    foreach (rdy_cyc[k]) if (st_cyc.size() > 0 && rdy_cyc[k] >= st_cyc[0] && rdy_cyc[k] <= irq_cyc) n_rdy++;
    checks++;
    if (n_hold != 0) begin
      errors++; $display("FAIL irq_holdoff: %0d strobes within 8 cycles of ack required 0", n_hold);
    end
    checks++;
    if (n_late == 0) begin
      errors++; $display("FAIL irq_retrigger: 0 strobes after holdoff required >=1");
    end
    checks++;
    if (n_rdy != 0) begin
      errors++; $display("FAIL irq_ready_low: req_ready high %0d cycles during service required 0", n_rdy);
    end
    int_n = 1'b1;
    tick(60);
  endtask

  task automatic test_irq_zero_status;
    resp_bytes[0] = 8'h00;
    clear_logs();
    int_n = 1'b0;
    tick(1);
    int_n = 1'b1;
    tick(30);
    checks++;
    if (st_data.size() != 2 || st_data[0] !== 8'h05 || st_data[1] !== 8'h00 || irq_cnt != 0) begin
      errors++; $display("FAIL irq_zero_status: %0d strobes irq %0d required 2 strobes (05 00) irq 0",
                         st_data.size(), irq_cnt);
    end
  endtask

  task automatic test_priority;
    logic [7:0] cmd;
    int c, n, n_rdy;
    cmd = 8'($urandom_range(16, 255));
    resp_bytes[0] = 8'h03; resp_bytes[1] = 8'h9A;
    clear_logs();
    n = 0;
    while (!req_ready && n < 100) begin tick(1); n++; end
    req_cmd = cmd; req_len = 4'd2; req_data = 56'hBEEF; req_valid = 1'b1; int_n = 1'b0; c = cyc;
    tick(1);
    req_valid = 1'b0;
    wait_rsp(60);
    wait_irq(100);
    int_n = 1'b1;
    tick(3);
    checks++;
    if (st_data.size() < 7 || st_data[0] !== cmd || st_data[1] !== 8'hEF || st_data[2] !== 8'hBE ||
        st_data[3] !== 8'h05 || st_data[4] !== 8'h00 || st_data[5] !== 8'h05 || st_data[6] !== 8'h03) begin
      errors++; $display("FAIL prio_order: %0d strobes first %h required %h EF BE 05 00 05 03",
                         st_data.size(), st_data.size() > 0 ? st_data[0] : 8'hxx, cmd);
    end
    checks++;
    if (st_cyc.size() < 4 || st_cyc[0] != c + 1 || st_cyc[3] <= rsp_cyc) begin
      errors++; $display("FAIL prio_host_first: host at +%0d, irq after rsp required host +1 then irq",
                         st_cyc.size() > 0 ? st_cyc[0] - c : -1);
    end
    checks++;
    if (rsp_cnt != 1 || rsp_data !== 56'h9A03 || irq_cnt != 1 || irq_status !== 8'h03) begin
      errors++; $display("FAIL prio_results: rsp %0d data %h irq %0d st %h required 1 9a03 1 03",
                         rsp_cnt, rsp_data, irq_cnt, irq_status);
    end
    n_rdy = 0;
    foreach (rdy_cyc[k]) if (st_cyc.size() > 3 && rdy_cyc[k] >= st_cyc[3] && rdy_cyc[k] <= irq_cyc) n_rdy++;
    checks++;
    if (n_rdy != 0) begin
      errors++; $display("FAIL prio_ready_low: req_ready high %0d cycles during irq required 0", n_rdy);
    end
    tick(20);
  endtask

  task automatic test_reset_mid;
    int c;
    clear_logs();
    launch(8'h33, 4'd3, 56'h112233, c);
    while (cyc < c + 9) tick(1);
    checks++;
    if (strobe !== 1'b1 || tx_data !== 8'h22) begin
      errors++; $display("FAIL rstmid_at_strobe: strobe %0b tx %h required 1 22", strobe, tx_data);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (strobe !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: strobe %0b busy %0b ready %0b required 0 0 0",
                         strobe, busy, req_ready);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: req_ready %0b required 1", req_ready);
    end
    clear_logs();
    tick(30);
    checks++;
    if (rsp_cnt != 0 || st_cyc.size() != 0) begin
      errors++; $display("FAIL rstmid_quiet: rsp %0d strobes %0d required 0 0", rsp_cnt, st_cyc.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) resp_bytes[k] = 8'h00;
    test_reset();
    test_basic_frames();
    test_random_requests();
    test_irq();
    test_irq_zero_status();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
